bfly_k: RTL and testbench
=========================

BFLY_K -- requirements
Module: bfly_K

Interface
REQ-001 Parameter Q, default 3329: Kyber modulus; taken from the shared package.
REQ-002 Parameter TAG_W, default 8: width of the sideband tag.
REQ-003 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n_i  input  1  reset, asynchronous, active-low.
REQ-005 valid_i  input  1  upstream presents a butterfly operand set.
REQ-006 ready_o  output  1  block accepts the operand set this cycle.
REQ-007 a_i  input  12  coefficient a, 0 <= a_i < Q.
REQ-008 b_i  input  12  coefficient b, 0 <= b_i < Q.
REQ-009 w_i  input  12  twiddle factor, 0 <= w_i < Q.
REQ-010 tag_i  input  TAG_W  sideband (coefficient index); passed through unchanged.
REQ-011 valid_o  output  1  result is valid.
REQ-012 ready_i  input  1  downstream accepts the result.
REQ-013 a_o  output  12  (a + t) mod Q.
REQ-014 b_o  output  12  (a - t) mod Q.
REQ-015 tag_o  output  TAG_W  tag aligned with a_o/b_o.

Function
REQ-016 Cooley-Tukey butterfly: t = (b_i * w_i) mod Q; a_o = (a+t) mod Q; b_o = (a-t) mod Q.
REQ-017 Three-stage pipeline, each stage holding a valid bit and data:
- S1: 24-bit product b*w, a, tag.
- S2: t = Barrett-reduced S1 product, a, tag.
- S3: a_o, b_o, tag.
REQ-018 Product is a full 24-bit unsigned result; 3328*3328 = 11075584 fits, no truncation.
REQ-019 a+t computed 13-bit; subtract Q when the sum >= Q.
REQ-020 a-t computed 13-bit; add Q when a < t; both results always in [0, Q-1].
REQ-021 Transfer in: valid_i && ready_o. Transfer out: valid_o && ready_i.
REQ-022 Global stall: advance = !valid_o || ready_i.
- ready_o = advance.
- All stages (valid bits and data) load only when advance = 1.
- Bubbles are not collapsed.
REQ-023 Latency: exactly 3 cycles, input accept edge to valid_o high, when ready_i is held 1.
REQ-024 Throughput: one butterfly per cycle while ready_i = 1.
REQ-025 Stall behaviour: valid_o && !ready_i holds a_o, b_o, tag_o and every stage stable; no data lost or duplicated.
REQ-026 ready_o may depend combinationally on ready_i; valid_o and data outputs come directly from S3 registers.
REQ-027 Order preservation: results leave in acceptance order, tags unchanged.
REQ-028 Input-range policy: behaviour for a_i, b_i or w_i >= Q is unspecified; the bench does not drive such values.

Reset
REQ-029 rst_n_i low asynchronously clears all three stage valid bits; valid_o = 0 immediately.
REQ-030 During reset: a_o = 0, b_o = 0, tag_o = 0; ready_o = 1.
REQ-031 Data registers of S1 and S2 need no reset; only valid bits and S3 outputs are reset.
REQ-032 Reset mid-operation discards all in-flight butterflies; none appear after reset release.

Structure
REQ-033 Shared package kyber_pkg holds Q = 3329, COEF_W = 12, PROD_W = 24 and the Barrett constants; bfly_K and red_K both import it.
REQ-034 Exactly one sub-module: red_K, instantiated between S1 and S2 (24-bit product in, 12-bit t out).
REQ-035 Reduction is not re-implemented inside bfly_K.

Verification
REQ-036 a=0, b=1, w=1, tag=0x01, ready_i=1 -> 3 cycles later: a_o=1, b_o=3328, tag_o=0x01.
REQ-037 a=3328, b=3328, w=3328 -> t=1; a_o=0, b_o=3327 (wrap in both directions).
REQ-038 a=100, b=2, w=3000 -> t=2671; a_o=2771, b_o=758.
REQ-039 Stream 5 back-to-back sets, ready_i low for cycles 4-6 -> ready_o low while valid_o && !ready_i; outputs held; all 5 results exit in order, no loss or duplication.
REQ-040 Assert rst_n_i with 2 sets in flight -> valid_o=0 at once; no result appears after release; next input returns after 3 cycles.
REQ-041 Random legal operands, 10000 sets, random ready_i -> scoreboard matches reference model; a_o and b_o always < 3329.

Source files
------------

// File: rtl/kyber_pkg.sv
// Shared Kyber arithmetic constants and types for the NTT butterfly datapath.
package kyber_pkg;

    localparam int unsigned Q      = 3329;
    localparam int unsigned COEF_W = 12;
    localparam int unsigned PROD_W = 24;

    // Barrett reduction: q_est = (x * M) >> K with M = floor(2^K / Q).
    // K = 26 keeps q_est within one of the true quotient for any 24-bit x,
    // so a single conditional subtract finishes the reduction.
    localparam int unsigned BARRETT_K = 26;
    localparam int unsigned BARRETT_W = 16;

    typedef logic [COEF_W-1:0] coef_t;
    typedef logic [PROD_W-1:0] prod_t;

    function automatic int unsigned barrett_m(input int unsigned q);
        return (32'd1 << BARRETT_K) / q;
    endfunction

    localparam int unsigned BARRETT_M = (32'd1 << BARRETT_K) / Q;

endpackage

// File: rtl/bfly_k_red.sv
// Barrett reduction of a 24-bit product modulo Q (combinational).
module red_K
    import kyber_pkg::*;
#(
    parameter int unsigned Q = kyber_pkg::Q
) (
    input  logic [PROD_W-1:0] x_i,
    output logic [COEF_W-1:0] r_o
);

    localparam int unsigned MUL_W = PROD_W + BARRETT_W;
    localparam logic [BARRETT_W-1:0] M = BARRETT_W'(barrett_m(Q));

    logic [MUL_W-1:0]  xm;
    logic [PROD_W-1:0] q_est;
    logic [PROD_W-1:0] rem;

    // Estimate quotient, remove it, then fix the at-most-one-Q overshoot.
    always_comb begin
        xm    = MUL_W'(x_i) * MUL_W'(M);
        q_est = PROD_W'(xm >> BARRETT_K);
        rem   = x_i - PROD_W'(q_est * PROD_W'(Q));
        if (rem >= PROD_W'(Q)) begin
            r_o = COEF_W'(rem - PROD_W'(Q));
        end else begin
            r_o = COEF_W'(rem);
        end
    end

endmodule

// File: rtl/bfly_k.sv
// Cooley-Tukey butterfly mod Q, three-stage valid/ready pipeline with global stall.
module bfly_k
    import kyber_pkg::*;
#(
    parameter int unsigned Q     = kyber_pkg::Q,
    parameter int unsigned TAG_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [COEF_W-1:0] a_i,
    input  logic [COEF_W-1:0] b_i,
    input  logic [COEF_W-1:0] w_i,
    input  logic [TAG_W-1:0]  tag_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [COEF_W-1:0] a_o,
    output logic [COEF_W-1:0] b_o,
    output logic [TAG_W-1:0]  tag_o
);

    localparam int unsigned SUM_W = COEF_W + 1;

    logic              advance;
    logic [COEF_W-1:0] t_red;
    logic [SUM_W-1:0]  sum;
    logic [SUM_W-1:0]  diff;
    logic [COEF_W-1:0] sum_mod;
    logic [COEF_W-1:0] diff_mod;

    logic              s1_valid_d, s1_valid_q;
    logic [PROD_W-1:0] s1_prod_d,  s1_prod_q;
    logic [COEF_W-1:0] s1_a_d,     s1_a_q;
    logic [TAG_W-1:0]  s1_tag_d,   s1_tag_q;

    logic              s2_valid_d, s2_valid_q;
    logic [COEF_W-1:0] s2_t_d,     s2_t_q;
    logic [COEF_W-1:0] s2_a_d,     s2_a_q;
    logic [TAG_W-1:0]  s2_tag_d,   s2_tag_q;

    logic              s3_valid_d, s3_valid_q;
    logic [COEF_W-1:0] s3_a_d,     s3_a_q;
    logic [COEF_W-1:0] s3_b_d,     s3_b_q;
    logic [TAG_W-1:0]  s3_tag_d,   s3_tag_q;

    red_K #(.Q(Q)) u_red (
        .x_i (s1_prod_q),
        .r_o (t_red)
    );

    // Modular add/sub of a and t; both operands are already in [0, Q-1].
    always_comb begin
        sum = {1'b0, s2_a_q} + {1'b0, s2_t_q};
        if (sum >= SUM_W'(Q)) begin
            sum_mod = COEF_W'(sum - SUM_W'(Q));
        end else begin
            sum_mod = COEF_W'(sum);
        end
        diff = {1'b0, s2_a_q} - {1'b0, s2_t_q};
        if (s2_a_q < s2_t_q) begin
            diff = diff + SUM_W'(Q);
        end
        diff_mod = COEF_W'(diff);
    end

    // Global stall: all stages shift together only when the output slot frees up.
    always_comb begin
        advance    = !s3_valid_q || ready_i;
        s1_valid_d = s1_valid_q;
        s1_prod_d  = s1_prod_q;
        s1_a_d     = s1_a_q;
        s1_tag_d   = s1_tag_q;
        s2_valid_d = s2_valid_q;
        s2_t_d     = s2_t_q;
        s2_a_d     = s2_a_q;
        s2_tag_d   = s2_tag_q;
        s3_valid_d = s3_valid_q;
        s3_a_d     = s3_a_q;
        s3_b_d     = s3_b_q;
        s3_tag_d   = s3_tag_q;
        if (advance) begin
            s1_valid_d = valid_i;
            s1_prod_d  = PROD_W'(b_i) * PROD_W'(w_i);
            s1_a_d     = a_i;
            s1_tag_d   = tag_i;
            s2_valid_d = s1_valid_q;
            s2_t_d     = t_red;
            s2_a_d     = s1_a_q;
            s2_tag_d   = s1_tag_q;
            s3_valid_d = s2_valid_q;
            s3_a_d     = sum_mod;
            s3_b_d     = diff_mod;
            s3_tag_d   = s2_tag_q;
        end
    end

    // Valid bits and output stage are reset; reset drops everything in flight.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
            s3_a_q     <= '0;
            s3_b_q     <= '0;
            s3_tag_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s3_valid_q <= s3_valid_d;
            s3_a_q     <= s3_a_d;
            s3_b_q     <= s3_b_d;
            s3_tag_q   <= s3_tag_d;
        end
    end

    // Intermediate data needs no reset; its valid bit qualifies it.
    always_ff @(posedge clk_i) begin
        s1_prod_q <= s1_prod_d;
        s1_a_q    <= s1_a_d;
        s1_tag_q  <= s1_tag_d;
        s2_t_q    <= s2_t_d;
        s2_a_q    <= s2_a_d;
        s2_tag_q  <= s2_tag_d;
    end

    assign ready_o = advance;
    assign valid_o = s3_valid_q;
    assign a_o     = s3_a_q;
    assign b_o     = s3_b_q;
    assign tag_o   = s3_tag_q;

endmodule

// File: tb/tb_bfly_k.sv
// Self-checking bench for bfly_k: directed vectors, stall, reset and random traffic.
module tb_bfly_k;

    localparam int unsigned Q     = 3329;
    localparam int unsigned TAG_W = 8;

    logic             clk_i   = 1'b0;
    logic             rst_n_i = 1'b0;
    logic             valid_i = 1'b0;
    logic             ready_o;
    logic [11:0]      a_i     = '0;
    logic [11:0]      b_i     = '0;
    logic [11:0]      w_i     = '0;
    logic [TAG_W-1:0] tag_i   = '0;
    logic             valid_o;
    logic             ready_i = 1'b0;
    logic [11:0]      a_o;
    logic [11:0]      b_o;
    logic [TAG_W-1:0] tag_o;

    typedef struct {
        int unsigned a;
        int unsigned b;
        int unsigned tag;
    } res_t;

    res_t        exp_q[$];
    int unsigned checks = 0;
    int unsigned errors = 0;
    bit          stall_prev = 1'b0;
    int unsigned prev_a, prev_b, prev_tag;
    bit          acc;
    bit          got;
    int unsigned got_a, got_b, got_tag;

    always #5 clk_i = ~clk_i;

    bfly_k #(.Q(Q), .TAG_W(TAG_W)) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .a_i     (a_i),
        .b_i     (b_i),
        .w_i     (w_i),
        .tag_i   (tag_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .a_o     (a_o),
        .b_o     (b_o),
        .tag_o   (tag_o)
    );

    task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference butterfly straight from the modular definition.
    function automatic res_t model(input int unsigned a, input int unsigned b,
                                   input int unsigned w, input int unsigned tag);
        res_t        r;
        int unsigned t;
        t     = (b * w) % Q;
        r.a   = (a + t) % Q;
        r.b   = (a + Q - t) % Q;
        r.tag = tag;
        return r;
    endfunction

    // One clock cycle: drive inputs, sample at negedge, score, return to posedge+1.
    task automatic cycle(input bit v, input int unsigned a, input int unsigned b,
                         input int unsigned w, input int unsigned tag, input bit rdy);
        res_t e;
        valid_i = v;
        a_i     = 12'(a);
        b_i     = 12'(b);
        w_i     = 12'(w);
        tag_i   = TAG_W'(tag);
        ready_i = rdy;
        @(negedge clk_i);
        if (stall_prev) begin
            check_eq("hold_valid", 32'(valid_o), 1);
            check_eq("hold_a", 32'(a_o), prev_a);
            check_eq("hold_b", 32'(b_o), prev_b);
            check_eq("hold_tag", 32'(tag_o), prev_tag);
        end
        check_eq("ready_o", 32'(ready_o), (valid_o && !ready_i) ? 0 : 1);
        got = 1'b0;
        if (valid_o) begin
            check_eq("a_range", 32'(a_o < 12'(Q)), 1);
            check_eq("b_range", 32'(b_o < 12'(Q)), 1);
        end
        if (valid_o && ready_i) begin
            got     = 1'b1;
            got_a   = 32'(a_o);
            got_b   = 32'(b_o);
            got_tag = 32'(tag_o);
            check_eq("pending", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_eq("a_o", 32'(a_o), e.a);
                check_eq("b_o", 32'(b_o), e.b);
                check_eq("tag_o", 32'(tag_o), e.tag);
            end
        end
        acc = valid_i && ready_o;
        if (acc) exp_q.push_back(model(a, b, w, tag % 256));
        stall_prev = valid_o && !ready_i;
        prev_a     = 32'(a_o);
        prev_b     = 32'(b_o);
        prev_tag   = 32'(tag_o);
        @(posedge clk_i);
        #1;
    endtask

    // Single butterfly with ready_i high: checks latency and literal results.
    task automatic run_one(input string name, input int unsigned a, input int unsigned b,
                           input int unsigned w, input int unsigned tag,
                           input int unsigned ea, input int unsigned eb);
        int unsigned lat;
        cycle(1'b1, a, b, w, tag, 1'b1);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 10) begin
            cycle(1'b0, 0, 0, 0, 0, 1'b1);
            lat++;
        end
        check_eq({name, "_latency"}, lat, 3);
        check_eq({name, "_a"}, got_a, ea);
        check_eq({name, "_b"}, got_b, eb);
        check_eq({name, "_tag"}, got_tag, tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned idx;
        int unsigned acc_n;
        int unsigned cyc;
        int unsigned ca, cb, cw, ct;

        // Reset state
        rst_n_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check_eq("rst_valid_o", 32'(valid_o), 0);
        check_eq("rst_a_o", 32'(a_o), 0);
        check_eq("rst_b_o", 32'(b_o), 0);
        check_eq("rst_tag_o", 32'(tag_o), 0);
        check_eq("rst_ready_o", 32'(ready_o), 1);
        rst_n_i = 1'b1;

        // Directed vectors
        run_one("v1", 0, 1, 1, 8'h01, 1, 3328);
        run_one("v2", 3328, 3328, 3328, 8'h02, 0, 3327);
        run_one("v3", 100, 2, 3000, 8'h03, 2771, 758);

        // Five back-to-back sets, downstream stalls in cycles 4-6
        idx = 0;
        for (int c = 1; c <= 40 && (idx < 5 || exp_q.size() > 0); c++) begin
            cycle(idx < 5, 10 + idx * 7, 3000 - idx, 17 + idx, 8'h20 + idx,
                  !(c >= 4 && c <= 6));
            if (acc) idx++;
        end
        check_eq("stall_sent", idx, 5);
        check_eq("stall_drained", exp_q.size(), 0);

        // Reset with two sets in flight
        cycle(1'b1, 5, 6, 7, 8'h31, 1'b1);
        cycle(1'b1, 8, 9, 10, 8'h32, 1'b1);
        rst_n_i = 1'b0;
        #1;
        check_eq("midrst_valid_o", 32'(valid_o), 0);
        check_eq("midrst_a_o", 32'(a_o), 0);
        check_eq("midrst_b_o", 32'(b_o), 0);
        check_eq("midrst_tag_o", 32'(tag_o), 0);
        check_eq("midrst_ready_o", 32'(ready_o), 1);
        exp_q.delete();
        stall_prev = 1'b0;
        valid_i    = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        repeat (6) cycle(1'b0, 0, 0, 0, 0, 1'b1);
        run_one("post_rst", 1234, 567, 890, 8'h44,
                (1234 + (567 * 890) % Q) % Q, (1234 + Q - (567 * 890) % Q) % Q);

        // Random traffic with random back-pressure; a set is held until accepted
        acc_n = 0;
        cyc   = 0;
        ca = $urandom_range(0, Q - 1);
        cb = $urandom_range(0, Q - 1);
        cw = $urandom_range(0, Q - 1);
        ct = $urandom_range(0, 255);
        while (acc_n < 10000 && cyc < 60000) begin
            cycle($urandom_range(0, 9) < 8, ca, cb, cw, ct, $urandom_range(0, 3) != 0);
            cyc++;
            if (acc) begin
                acc_n++;
                ca = $urandom_range(0, Q - 1);
                cb = $urandom_range(0, Q - 1);
                cw = $urandom_range(0, Q - 1);
                ct = $urandom_range(0, 255);
            end
        end
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) begin
            cycle(1'b0, 0, 0, 0, 0, 1'b1);
        end
        check_eq("rand_sent", acc_n, 10000);
        check_eq("rand_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
